// File: rtl/axis_adder_pkg.sv
// Shared widths and the zero-extended sum used by the two-input stream adder.
package axis_adder_pkg;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 16;

  // Widen before adding so the carry out of the operand width is preserved.
  function automatic logic [OUT_W-1:0] zext_sum(input logic [IN_W-1:0] a,
                                                input logic [IN_W-1:0] b);
    return OUT_W'(a) + OUT_W'(b);
  endfunction

endpackage

// File: rtl/axis_8bit_adder_if.sv
// Single AXI-Stream channel: payload, valid and ready.
interface axis_8bit_adder_if #(
  parameter int unsigned W = 8
);

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/axis_hold_reg.sv
// One-entry stream holding register; refills on the same edge it is popped.
module axis_hold_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         ready_c,
  input  logic         pop,
  output logic         full,
  output logic [W-1:0] data
);

  // Readies stay low during reset so nothing is sampled then.
  assign ready_c = !rst && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && ready_c) begin
      full <= 1'b1;
      data <= in_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_8bit_adder.sv
// Two-input AXI-Stream adder: pairs beats in order, emits the zero-extended sum.
module axis_8bit_adder
  import axis_adder_pkg::*;
(
  input logic              clk,
  input logic              rst,
  axis_8bit_adder_if.slave  s_axis1,
  axis_8bit_adder_if.slave  s_axis2,
  axis_8bit_adder_if.master m_axis
);

  logic            full1;
  logic            full2;
  logic [IN_W-1:0] hold1;
  logic [IN_W-1:0] hold2;
  logic            fire_c;
  logic [OUT_W-1:0] sum_q;
  logic            valid_q;

  // Fire when both operands are held and the output slot is free or draining.
  assign fire_c = !rst && full1 && full2 && (!valid_q || m_axis.ready);

  axis_hold_reg #(.W(IN_W)) u_hold1 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s_axis1.data),
    .in_valid (s_axis1.valid),
    .ready_c  (s_axis1.ready),
    .pop      (fire_c),
    .full     (full1),
    .data     (hold1)
  );

  axis_hold_reg #(.W(IN_W)) u_hold2 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s_axis2.data),
    .in_valid (s_axis2.valid),
    .ready_c  (s_axis2.ready),
    .pop      (fire_c),
    .full     (full2),
    .data     (hold2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else if (fire_c) begin
      sum_q   <= zext_sum(hold1, hold2);
      valid_q <= 1'b1;
    end else if (m_axis.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign m_axis.data  = sum_q;
  assign m_axis.valid = valid_q;

endmodule

// File: tb/tb_axis_8bit_adder.sv
// Directed bench for axis_8bit_adder with an in-order pairing reference model.
module tb_axis_8bit_adder;
  import axis_adder_pkg::*;

  logic clk;
  logic rst;

  axis_8bit_adder_if #(.W(IN_W))  s1 ();
  axis_8bit_adder_if #(.W(IN_W))  s2 ();
  axis_8bit_adder_if #(.W(OUT_W)) m  ();

  axis_8bit_adder dut (
    .clk     (clk),
    .rst     (rst),
    .s_axis1 (s1),
    .s_axis2 (s2),
    .m_axis  (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [IN_W-1:0]  qa[$];
  logic [IN_W-1:0]  qb[$];
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] out_log[$];
  logic             stall_prev = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: operands queue per port, sums pair the oldest of each, in order.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(m.valid), 32'd1);
        check("stall_data", 32'(m.data), 32'(prev_data));
      end
      if (m.valid && m.ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(m.data), 32'hFFFF_FFFF);
        end else begin
          check("sum", 32'(m.data), 32'(exp_q.pop_front()));
        end
        out_log.push_back(m.data);
      end
      if (s1.valid && s1.ready) qa.push_back(s1.data);
      if (s2.valid && s2.ready) qb.push_back(s2.data);
      while (qa.size() > 0 && qb.size() > 0)
        exp_q.push_back(OUT_W'(qa.pop_front()) + OUT_W'(qb.pop_front()));
      stall_prev = m.valid && !m.ready;
      prev_data  = m.data;
    end
  end

  task automatic one_pair(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                          input logic [OUT_W-1:0] exp, input string tag);
    out_log.delete();
    tick();
    s1.valid = 1'b1; s1.data = a;
    s2.valid = 1'b1; s2.data = b;
    m.ready  = 1'b1;
    @(negedge clk);
    check({tag, "_rdy1"}, 32'(s1.ready), 32'd1);
    check({tag, "_rdy2"}, 32'(s2.ready), 32'd1);
    tick();
    s1.valid = 1'b0; s2.valid = 1'b0;
    @(negedge clk);
    check({tag, "_not_early"}, 32'(m.valid), 32'd0);
    tick();
    @(negedge clk);
    check({tag, "_valid"}, 32'(m.valid), 32'd1);
    check({tag, "_data"}, 32'(m.data), 32'(exp));
    tick();
    @(negedge clk);
    check({tag, "_one_beat"}, 32'(m.valid), 32'd0);
    check({tag, "_count"}, 32'(out_log.size()), 32'd1);
  endtask

  initial begin
    logic h1, h2;
    int   a1, a2;

    rst = 1'b1;
    s1.valid = 1'b0; s1.data = '0;
    s2.valid = 1'b0; s2.data = '0;
    m.ready  = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_valid", 32'(m.valid), 32'd0);
    check("rst_data", 32'(m.data), 32'd0);
    check("rst_rdy1", 32'(s1.ready), 32'd0);
    check("rst_rdy2", 32'(s2.ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy1", 32'(s1.ready), 32'd1);
    check("post_rst_rdy2", 32'(s2.ready), 32'd1);
    check("post_rst_valid", 32'(m.valid), 32'd0);

    one_pair(8'h12, 8'h34, 16'h0046, "pair");
    one_pair(8'hFF, 8'hFF, 16'h01FE, "max");
    one_pair(8'h00, 8'h00, 16'h0000, "zero");

    // Skewed arrival: A held six cycles before B shows up
    out_log.delete();
    tick();
    s1.valid = 1'b1; s1.data = 8'h05;
    @(negedge clk);
    tick();
    s1.valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("skew_rdy1_low", 32'(s1.ready), 32'd0);
      check("skew_no_valid", 32'(m.valid), 32'd0);
      tick();
    end
    s2.valid = 1'b1; s2.data = 8'h07;
    @(negedge clk);
    check("skew_rdy1_wait", 32'(s1.ready), 32'd0);
    check("skew_rdy2", 32'(s2.ready), 32'd1);
    tick();
    s2.valid = 1'b0;
    @(negedge clk);
    check("skew_rdy1_fire", 32'(s1.ready), 32'd1);
    check("skew_not_early", 32'(m.valid), 32'd0);
    tick();
    @(negedge clk);
    check("skew_valid", 32'(m.valid), 32'd1);
    check("skew_data", 32'(m.data), 32'h000C);
    tick();
    @(negedge clk);
    check("skew_one_beat", 32'(m.valid), 32'd0);

    // Output stall with continuous operands 1..n on both ports
    out_log.delete();
    tick();
    m.ready = 1'b0;
    s1.valid = 1'b1; s1.data = 8'd1;
    s2.valid = 1'b1; s2.data = 8'd1;
    a1 = 0; a2 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      h1 = s1.valid && s1.ready;
      h2 = s2.valid && s2.ready;
      if (h1) a1++;
      if (h2) a2++;
      tick();
      if (h1) s1.data = s1.data + 8'd1;
      if (h2) s2.data = s2.data + 8'd1;
    end
    @(negedge clk);
    check("stall_accept1", 32'(a1), 32'd2);
    check("stall_accept2", 32'(a2), 32'd2);
    check("stall_rdy1", 32'(s1.ready), 32'd0);
    check("stall_rdy2", 32'(s2.ready), 32'd0);
    check("stall_first", 32'(m.data), 32'd2);
    tick();
    m.ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (!s1.valid && !s2.valid) break;
      @(negedge clk);
      h1 = s1.valid && s1.ready;
      h2 = s2.valid && s2.ready;
      tick();
      if (h1) begin
        if (s1.data == 8'd6) s1.valid = 1'b0;
        else s1.data = s1.data + 8'd1;
      end
      if (h2) begin
        if (s2.data == 8'd6) s2.valid = 1'b0;
        else s2.data = s2.data + 8'd1;
      end
    end
    s1.valid = 1'b0; s2.valid = 1'b0;
    repeat (4) tick();
    check("stall_count", 32'(out_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      check("stall_order", 32'(out_log[i]), 32'(2 * (i + 1)));

    // Streaming: one sum per cycle with random operands
    out_log.delete();
    tick();
    m.ready = 1'b1;
    s1.valid = 1'b1; s1.data = 8'($urandom_range(0, 255));
    s2.valid = 1'b1; s2.data = 8'($urandom_range(0, 255));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("stream_rdy1", 32'(s1.ready), 32'd1);
      check("stream_rdy2", 32'(s2.ready), 32'd1);
      if (c >= 2) check("stream_valid", 32'(m.valid), 32'd1);
      tick();
      s1.data = 8'($urandom_range(0, 255));
      s2.data = 8'($urandom_range(0, 255));
    end
    s1.valid = 1'b0; s2.valid = 1'b0;
    repeat (4) tick();
    check("stream_count", 32'(out_log.size()), 32'd20);

    // Reset mid-flight discards a held operand
    out_log.delete();
    s1.valid = 1'b1; s1.data = 8'h09;
    @(negedge clk);
    tick();
    s1.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(m.valid), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_after_valid", 32'(m.valid), 32'd0);
    check("midrst_rdy1", 32'(s1.ready), 32'd1);
    tick();
    s1.valid = 1'b1; s1.data = 8'h04;
    s2.valid = 1'b1; s2.data = 8'h03;
    @(negedge clk);
    tick();
    s1.valid = 1'b0; s2.valid = 1'b0;
    @(negedge clk);
    check("midrst_not_early", 32'(m.valid), 32'd0);
    tick();
    @(negedge clk);
    check("midrst_sum_valid", 32'(m.valid), 32'd1);
    check("midrst_sum", 32'(m.data), 32'h0007);
    repeat (3) tick();
    check("midrst_count", 32'(out_log.size()), 32'd1);
    check("end_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
